// File: rtl/lsu_mem_stage_pkg.sv
// Shared types for the RV32I memory-stage LSU: FSM states, load/store funct3 codes
// and the misalignment rule used when trapping is enabled.
package lsu_mem_stage_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

  typedef logic [2:0] mem_funct3_t;

  localparam mem_funct3_t LB  = 3'b000;
  localparam mem_funct3_t LH  = 3'b001;
  localparam mem_funct3_t LW  = 3'b010;
  localparam mem_funct3_t LBU = 3'b100;
  localparam mem_funct3_t LHU = 3'b101;
  localparam mem_funct3_t SB  = 3'b000;
  localparam mem_funct3_t SH  = 3'b001;
  localparam mem_funct3_t SW  = 3'b010;

  // Size comes from funct3[1:0]; reserved codes are treated as words.
  function automatic logic misaligned(input mem_funct3_t f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = off[0];
      default: misaligned = (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store data replication / byte strobes and
// load byte/halfword selection with sign or zero extension.
module lsu_align
  import lsu_mem_stage_pkg::*;
(
  input  mem_funct3_t funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] load_data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    lane_byte = 8'(load_word >> {offset, 3'b000});
    lane_half = offset[1] ? load_word[31:16] : load_word[15:0];

    wstrb = 4'b1111;
    wdata = store_data;
    case (funct3)
      SB: begin
        wstrb = 4'b0001 << offset;
        wdata = {4{store_data[7:0]}};
      end
      SH: begin
        wstrb = 4'b0011 << {offset[1], 1'b0};
        wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase

    case (funct3)
      LB:      load_data = {{24{lane_byte[7]}}, lane_byte};
      LBU:     load_data = {24'b0, lane_byte};
      LH:      load_data = {{16{lane_half[15]}}, lane_half};
      LHU:     load_data = {16'b0, lane_half};
      default: load_data = load_word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: valid/ready bus request FSM, read capture and stall.
// Optional MISALIGN_TRAP_EN: misaligned accesses raise misalign_m instead of going to the bus.
module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_m,
  input  logic              mem_write_m,
  input  logic [2:0]        funct3_m,
  input  logic [ADDR_W-1:0] mem_addr_m,
  input  logic [DATA_W-1:0] mem_data_m,
  output logic [DATA_W-1:0] read_data_m,
  output logic              stall_m,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [3:0]        bus_wstrb,
  input  logic              bus_rsp_valid,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              misalign_m
);

  lsu_state_t        state;
  logic [DATA_W-1:0] rdata_q;
  logic              rst_q;
  logic              gate;
  logic              access;
  logic              trap;
  logic              req;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        wstrb;
  logic [DATA_W-1:0] load_data;

  lsu_align u_align (
    .funct3     (funct3_m),
    .offset     (mem_addr_m[1:0]),
    .store_data (mem_data_m),
    .load_word  (rdata_q),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .load_data  (load_data)
  );

  // Outputs stay quiet during reset and for one cycle after it.
  assign gate   = rst | rst_q;
  assign access = mem_read_m | mem_write_m;

`ifdef MISALIGN_TRAP_EN
  assign trap = ~gate & access & (state == IDLE) & misaligned(funct3_m, mem_addr_m[1:0]);
`else
  assign trap = 1'b0;
`endif

  assign req = ~gate & access & ~trap & ((state == IDLE) | (state == REQ));

  always_comb begin
    bus_req_valid = req;
    bus_we        = req & mem_write_m;
    bus_addr      = req ? {mem_addr_m[ADDR_W-1:2], 2'b00} : '0;
    bus_wdata     = (req & mem_write_m) ? wdata : '0;
    bus_wstrb     = (req & mem_write_m) ? wstrb : '0;
    stall_m       = ~gate & access & ~trap & (state != DONE);
    misalign_m    = trap;
    read_data_m   = (gate | trap) ? '0 : load_data;
  end

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      state   <= IDLE;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (trap) begin
            state <= DONE;
          end else if (req) begin
            if (!bus_req_ready) state <= REQ;
            else if (mem_write_m) state <= DONE;
            else state <= WAIT;
          end
        end
        REQ: begin
          if (req && bus_req_ready) begin
            if (mem_write_m) state <= DONE;
            else state <= WAIT;
          end
        end
        WAIT: begin
          if (bus_rsp_valid) begin
            rdata_q <= bus_rdata;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: expected requests/results queued per access,
// checked by a negedge monitor as the bus request and completion appear.
module tb_lsu_mem_stage;
  import lsu_mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read_m = 1'b0;
  logic        mem_write_m = 1'b0;
  logic [2:0]  funct3_m = 3'b000;
  logic [31:0] mem_addr_m = '0;
  logic [31:0] mem_data_m = '0;
  logic [31:0] read_data_m;
  logic        stall_m;
  logic        bus_req_valid;
  logic        bus_req_ready = 1'b0;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_rsp_valid = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        misalign_m;

  lsu_mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_read_m    (mem_read_m),
    .mem_write_m   (mem_write_m),
    .funct3_m      (funct3_m),
    .mem_addr_m    (mem_addr_m),
    .mem_data_m    (mem_data_m),
    .read_data_m   (read_data_m),
    .stall_m       (stall_m),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_we        (bus_we),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_wstrb     (bus_wstrb),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rdata     (bus_rdata),
    .misalign_m    (misalign_m)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] rdata;
    logic        mis;
    int unsigned stalls;
    int unsigned valids;
  } exp_t;

  exp_t        q[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned stall_cnt = 0;
  int unsigned valid_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] addr, input logic we, input logic [3:0] wstrb,
                              input logic [31:0] wdata, input logic chk_rd, input logic [31:0] rdata,
                              input logic mis, input int unsigned stalls, input int unsigned valids);
    exp_t e;
    e.addr = addr; e.we = we; e.wstrb = wstrb; e.wdata = wdata; e.chk_rd = chk_rd;
    e.rdata = rdata; e.mis = mis; e.stalls = stalls; e.valids = valids;
    return e;
  endfunction

  // Monitor: request fields every valid cycle, then stall/valid counts and result at completion.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() == 0) begin
      stall_cnt = 0;
      valid_cnt = 0;
    end else begin
      if (bus_req_valid) begin
        valid_cnt++;
        check("req_addr", bus_addr, q[0].addr);
        check("req_we", 32'(bus_we), 32'(q[0].we));
        check("req_wstrb", 32'(bus_wstrb), 32'(q[0].wstrb));
        if (q[0].we) check("req_wdata", bus_wdata, q[0].wdata);
      end
      if (stall_m) begin
        stall_cnt++;
      end else if (mem_read_m | mem_write_m) begin
        e = q.pop_front();
        check("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
        check("valid_cycles", 32'(valid_cnt), 32'(e.valids));
        check("misalign", 32'(misalign_m), 32'(e.mis));
        if (e.chk_rd) check("read_data", read_data_m, e.rdata);
        stall_cnt = 0;
        valid_cnt = 0;
      end
    end
  end

  // Drives one M-stage access and plays the bus; ready is low for the first 'hold' cycles.
  task automatic txn(input bit wr, input bit rd, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] data, input logic [31:0] rword, input int unsigned hold,
                     input exp_t e);
    bit          hs;
    bit          done;
    int unsigned cyc;
    q.push_back(e);
    mem_write_m = wr; mem_read_m = rd; funct3_m = f3; mem_addr_m = addr; mem_data_m = data;
    bus_rdata = rword; bus_req_ready = (hold == 0); bus_rsp_valid = 1'b0;
    cyc = 0; done = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      if (!stall_m) begin
        done = 1'b1;
      end else begin
        hs = bus_req_valid & bus_req_ready;
        @(posedge clk); #1;
        cyc++;
        bus_rsp_valid = hs & rd & ~wr;
        bus_req_ready = (cyc >= hold);
      end
    end
    check("access_completed", 32'(done), 32'd1);
    if (!done && q.size() > 0) void'(q.pop_front());
    @(posedge clk); #1;
    mem_write_m = 1'b0; mem_read_m = 1'b0; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
  endtask

  initial begin
    // Reset with a load already presented: nothing may reach the bus during or just after reset.
    rst = 1'b1; mem_read_m = 1'b1; funct3_m = LW; mem_addr_m = 32'h40; bus_req_ready = 1'b1;
    @(negedge clk);
    check("rst_req_valid", 32'(bus_req_valid), 32'd0);
    check("rst_stall", 32'(stall_m), 32'd0);
    check("rst_read_data", read_data_m, 32'h0);
    check("rst_misalign", 32'(misalign_m), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("postrst_req_valid", 32'(bus_req_valid), 32'd0);
    check("postrst_stall", 32'(stall_m), 32'd0);
    check("postrst_addr", bus_addr, 32'h0);
    @(posedge clk); #1;
    mem_read_m = 1'b0; bus_req_ready = 1'b0;
    @(posedge clk); #1;

    txn(1, 0, SW, 32'h100, 32'hDEADBEEF, 32'h0, 0, mk(32'h100, 1, 4'b1111, 32'hDEADBEEF, 0, 0, 0, 1, 1));
    txn(1, 0, SB, 32'h103, 32'h000000A5, 32'h0, 0, mk(32'h100, 1, 4'b1000, 32'hA5A5A5A5, 0, 0, 0, 1, 1));
    txn(1, 0, SH, 32'h206, 32'h1234ABCD, 32'h0, 0, mk(32'h204, 1, 4'b1100, 32'hABCDABCD, 0, 0, 0, 1, 1));
    txn(1, 0, 3'b011, 32'h10C, 32'h01020304, 32'h0, 0, mk(32'h10C, 1, 4'b1111, 32'h01020304, 0, 0, 0, 1, 1));
    txn(0, 1, LB, 32'h102, 32'h0, 32'h12F45678, 0, mk(32'h100, 0, 4'b0000, 0, 1, 32'hFFFFFFF4, 0, 2, 1));
    txn(0, 1, LBU, 32'h102, 32'h0, 32'h12F45678, 0, mk(32'h100, 0, 4'b0000, 0, 1, 32'h000000F4, 0, 2, 1));
    txn(0, 1, LH, 32'h202, 32'h0, 32'h8001BEEF, 3, mk(32'h200, 0, 4'b0000, 0, 1, 32'hFFFF8001, 0, 5, 4));
    txn(0, 1, LHU, 32'h200, 32'h0, 32'h8001BEEF, 1, mk(32'h200, 0, 4'b0000, 0, 1, 32'h0000BEEF, 0, 3, 2));
    // Both strobes: the store wins and no read response is expected.
    txn(1, 1, SW, 32'h300, 32'h55AA33CC, 32'h0, 0, mk(32'h300, 1, 4'b1111, 32'h55AA33CC, 0, 0, 0, 1, 1));

    // Reset while waiting for a read; the late response must be dropped.
    mem_read_m = 1'b1; funct3_m = LW; mem_addr_m = 32'h300; bus_req_ready = 1'b1; bus_rdata = 32'h0;
    @(negedge clk);
    check("abort_req_valid", 32'(bus_req_valid), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; bus_req_ready = 1'b0;
    @(negedge clk);
    check("abort_rst_stall", 32'(stall_m), 32'd0);
    check("abort_rst_read_data", read_data_m, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; mem_read_m = 1'b0; bus_rsp_valid = 1'b1; bus_rdata = 32'hCAFEF00D;
    @(negedge clk);
    check("abort_late_stall", 32'(stall_m), 32'd0);
    check("abort_late_req_valid", 32'(bus_req_valid), 32'd0);
    @(posedge clk); #1;
    bus_rsp_valid = 1'b0;
    @(negedge clk);
    check("abort_rdata_kept_zero", read_data_m, 32'h0);
    @(posedge clk); #1;

    txn(0, 1, LW, 32'h300, 32'h0, 32'h11223344, 0, mk(32'h300, 0, 4'b0000, 0, 1, 32'h11223344, 0, 2, 1));

`ifdef MISALIGN_TRAP_EN
    txn(0, 1, LW, 32'h101, 32'h0, 32'hA1B2C3D4, 0, mk(32'h100, 0, 4'b0000, 0, 1, 32'h0, 1, 0, 0));
    @(negedge clk);
    check("misalign_one_cycle", 32'(misalign_m), 32'd0);
    @(posedge clk); #1;
`else
    txn(0, 1, LW, 32'h101, 32'h0, 32'hA1B2C3D4, 0, mk(32'h100, 0, 4'b0000, 0, 1, 32'hA1B2C3D4, 0, 2, 1));
`endif

    repeat (2) @(posedge clk);
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
